// File: rtl/sprite_sequencer_pkg.sv
// Shared types for the sprite sequencer: FSM state encoding, sprite table entry
// layout and the engine's sprite dimension.
package sprite_sequencer_pkg;

    localparam int unsigned SPR_DIM = 32;
    localparam int unsigned COORD_W = 9;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StLoad,
        StRun,
        StNext,
        StFin
    } seq_state_e;

    typedef struct packed {
        logic               en;
        logic [1:0]         id;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } spr_entry_t;

endpackage

// File: rtl/sprite_table.sv
// Sprite table: one synchronous write port, asynchronous read port, enable bits
// cleared by reset while id/x/y keep their contents.
module sprite_table
    import sprite_sequencer_pkg::*;
#(
    parameter int unsigned N_SPR = 4,
    parameter int unsigned AW    = $clog2(N_SPR)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  spr_entry_t    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output spr_entry_t    rdata_o
);

    logic [N_SPR-1:0]   en_q;
    logic [1:0]         id_q [N_SPR];
    logic [COORD_W-1:0] x_q  [N_SPR];
    logic [COORD_W-1:0] y_q  [N_SPR];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q <= '0;
        end else if (we_i) begin
            en_q[waddr_i] <= wdata_i.en;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            id_q[waddr_i] <= wdata_i.id;
            x_q[waddr_i]  <= wdata_i.x;
            y_q[waddr_i]  <= wdata_i.y;
        end
    end

    assign rdata_o = '{en: en_q[raddr_i], id: id_q[raddr_i], x: x_q[raddr_i], y: y_q[raddr_i]};

endmodule

// File: rtl/sprite_sequencer.sv
// Frame-draw sequencer: walks the sprite table in ascending index order and hands
// each enabled entry to the sprite engine, one at a time.
module sprite_sequencer
    import sprite_sequencer_pkg::*;
#(
    parameter int unsigned N_SPR = 4
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET_H,
    input  logic                       START,
    output logic                       BUSY,
    input  logic                       TBL_WE,
    input  logic [$clog2(N_SPR)-1:0]   TBL_ADDR,
    input  logic                       TBL_EN,
    input  logic [1:0]                 TBL_ID,
    input  logic [COORD_W-1:0]         TBL_X,
    input  logic [COORD_W-1:0]         TBL_Y,
    output logic                       UPDATE,
    output logic                       RUN_SPR,
    output logic [1:0]                 SPRITE_ID,
    output logic [COORD_W-1:0]         TARGET_X,
    output logic [COORD_W-1:0]         TARGET_Y,
    input  logic                       SPR_DONE,
    output logic                       DONE
);

    localparam int unsigned AW = $clog2(N_SPR);

    seq_state_e         state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load_tgt;
    logic [1:0]         id_q;
    logic [COORD_W-1:0] x_q, y_q;
    spr_entry_t         wr_entry, cur_entry;

    assign wr_entry = '{en: TBL_EN, id: TBL_ID, x: TBL_X, y: TBL_Y};

    sprite_table #(
        .N_SPR (N_SPR),
        .AW    (AW)
    ) u_table (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET_H),
        .we_i    (TBL_WE),
        .waddr_i (TBL_ADDR),
        .wdata_i (wr_entry),
        .raddr_i (idx_q),
        .rdata_o (cur_entry)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET_H) begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Targets are captured on entry to LOAD and held until the next LOAD, so a
    // table rewrite of the active entry cannot disturb a sprite mid-draw.
    always_ff @(posedge CLOCK_50) begin
        if (RESET_H) begin
            id_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
        end else if (load_tgt) begin
            id_q <= cur_entry.id;
            x_q  <= cur_entry.x;
            y_q  <= cur_entry.y;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load_tgt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (cur_entry.en) begin
                    load_tgt = 1'b1;
                    state_d  = StLoad;
                end else begin
                    state_d = StNext;
                end
            end
            StLoad: state_d = StRun;
            StRun: begin
                if (SPR_DONE) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (idx_q == AW'(N_SPR - 1)) begin
                    state_d = StFin;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = StScan;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign UPDATE    = (state_q == StLoad);
    // Combinational gating keeps the engine from stepping in the done cycle.
    assign RUN_SPR   = (state_q == StRun) && !SPR_DONE;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign SPRITE_ID = id_q;
    assign TARGET_X  = x_q;
    assign TARGET_Y  = y_q;

endmodule

// File: tb/tb_sprite_sequencer.sv
// Directed bench for sprite_sequencer with a counting sprite-engine model.
module tb_sprite_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       tbl_we = 1'b0;
    logic [1:0] tbl_addr = '0;
    logic       tbl_en = 1'b0;
    logic [1:0] tbl_id = '0;
    logic [8:0] tbl_x = '0;
    logic [8:0] tbl_y = '0;
    logic       update;
    logic       run_spr;
    logic [1:0] sprite_id;
    logic [8:0] target_x;
    logic [8:0] target_y;
    logic       spr_done;
    logic       done;

    always #10 clk = ~clk;

    sprite_sequencer #(.N_SPR(4)) dut (
        .CLOCK_50  (clk),
        .RESET_H   (rst),
        .START     (start),
        .BUSY      (busy),
        .TBL_WE    (tbl_we),
        .TBL_ADDR  (tbl_addr),
        .TBL_EN    (tbl_en),
        .TBL_ID    (tbl_id),
        .TBL_X     (tbl_x),
        .TBL_Y     (tbl_y),
        .UPDATE    (update),
        .RUN_SPR   (run_spr),
        .SPRITE_ID (sprite_id),
        .TARGET_X  (target_x),
        .TARGET_Y  (target_y),
        .SPR_DONE  (spr_done),
        .DONE      (done)
    );

    // Engine model: done once it has seen run_len cycles of RUN_SPR since UPDATE.
    int   run_len = 1024;
    int   run_cnt = 0;
    logic eng_auto = 1'b1;
    logic spr_done_man = 1'b0;

    always @(posedge clk) begin
        if (update) run_cnt <= 0;
        else if (run_spr) run_cnt <= run_cnt + 1;
    end

    assign spr_done = eng_auto ? (run_cnt == run_len) : spr_done_man;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic write_entry(input int a, input logic en, input logic [1:0] id,
                               input logic [8:0] x, input logic [8:0] y);
        @(negedge clk);
        tbl_we = 1'b1; tbl_addr = 2'(a); tbl_en = en; tbl_id = id; tbl_x = x; tbl_y = y;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    logic [1:0] upd_id [8];
    logic [8:0] upd_x  [8];
    logic [8:0] upd_y  [8];

    // cyc = cycles from the START cycle to the cycle DONE is seen high.
    task automatic run_frame(output int cyc, output int nupd, output int nrun,
                             output int nover, output logic to);
        cyc = 0; nupd = 0; nrun = 0; nover = 0; to = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        while (cyc < 6000) begin
            #1;
            start = 1'b0;
            cyc++;
            if (update) begin
                if (nupd < 8) begin
                    upd_id[nupd] = sprite_id; upd_x[nupd] = target_x; upd_y[nupd] = target_y;
                end
                nupd++;
            end
            if (run_spr) nrun++;
            if (update && run_spr) nover++;
            if (done) begin
                to = 1'b0;
                break;
            end
            @(posedge clk);
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        int         rl;
        int         exp_cyc;
        int         exp_upd;
        int         exp_run;
    } vec_t;

    vec_t       vecs [6];
    logic [1:0] id_tab [4];
    logic [8:0] x_tab  [4];
    logic [8:0] y_tab  [4];

    initial begin
        int cyc, nupd, nrun, nover, guard, bad, k;
        logic to;

        vecs[0] = '{4'b0000, 1024, 10,   0, 0};
        vecs[1] = '{4'b0100, 1024, 1036, 1, 1024};
        vecs[2] = '{4'b1111, 1024, 4114, 4, 4096};
        vecs[3] = '{4'b1010, 5,    24,   2, 10};
        vecs[4] = '{4'b1001, 0,    14,   2, 0};
        vecs[5] = '{4'b0001, 1,    13,   1, 1};
        id_tab = '{2'd0, 2'd1, 2'd2, 2'd3};
        x_tab  = '{9'd0, 9'd137, 9'd300, 9'd511};
        y_tab  = '{9'd511, 9'd50, 9'd256, 9'd1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset BUSY", 32'(busy), 0);
        check("reset DONE", 32'(done), 0);
        check("reset UPDATE", 32'(update), 0);
        check("reset RUN_SPR", 32'(run_spr), 0);
        check("reset SPRITE_ID", 32'(sprite_id), 0);
        check("reset TARGET_X", 32'(target_x), 0);
        check("reset TARGET_Y", 32'(target_y), 0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven frames
        foreach (vecs[v]) begin
            for (int i = 0; i < 4; i++) write_entry(i, vecs[v].mask[i], id_tab[i], x_tab[i], y_tab[i]);
            run_len = vecs[v].rl;
            run_frame(cyc, nupd, nrun, nover, to);
            check($sformatf("v%0d timeout", v), 32'(to), 0);
            check($sformatf("v%0d cycles", v), cyc, vecs[v].exp_cyc);
            check($sformatf("v%0d updates", v), nupd, vecs[v].exp_upd);
            check($sformatf("v%0d run cycles", v), nrun, vecs[v].exp_run);
            check($sformatf("v%0d update/run overlap", v), nover, 0);
            check($sformatf("v%0d busy after done", v), 32'(busy), 0);
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (vecs[v].mask[i] && k < nupd && k < 8) begin
                    check($sformatf("v%0d upd%0d id", v, k), 32'(upd_id[k]), 32'(id_tab[i]));
                    check($sformatf("v%0d upd%0d x", v, k), 32'(upd_x[k]), 32'(x_tab[i]));
                    check($sformatf("v%0d upd%0d y", v, k), 32'(upd_y[k]), 32'(y_tab[i]));
                    k++;
                end
            end
        end

        // Single entry 2 = {id 3, x 100, y 50}
        for (int i = 0; i < 4; i++) write_entry(i, i == 2, 2'd3, 9'd100, 9'd50);
        run_len = 1024;
        run_frame(cyc, nupd, nrun, nover, to);
        check("e2 cycles", cyc, 1036);
        check("e2 updates", nupd, 1);
        check("e2 id", 32'(upd_id[0]), 3);
        check("e2 x", 32'(upd_x[0]), 100);
        check("e2 y", 32'(upd_y[0]), 50);
        check("e2 run cycles", nrun, 1024);

        // Rewrite active entry during RUN
        for (int i = 0; i < 4; i++) write_entry(i, i == 0, 2'd1, 9'd10, 9'd20);
        run_len = 20;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!run_spr && guard < 10) begin
            @(posedge clk); #1; guard++;
        end
        check("rewrite reached RUN", 32'(run_spr), 1);
        @(negedge clk);
        tbl_we = 1'b1; tbl_addr = 2'd0; tbl_en = 1'b1; tbl_id = 2'd1; tbl_x = 9'd200; tbl_y = 9'd20;
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
        bad = 0; guard = 0;
        while (!done && guard < 100) begin
            if (target_x !== 9'd10) bad++;
            @(posedge clk); #1; guard++;
        end
        check("rewrite done seen", 32'(done), 1);
        check("rewrite x held", bad, 0);
        check("rewrite x after frame", 32'(target_x), 10);
        run_frame(cyc, nupd, nrun, nover, to);
        check("rewrite next frame x", 32'(upd_x[0]), 200);
        check("rewrite next frame cycles", cyc, 32);

        // START during RUN ignored, then SPR_DONE in IDLE ignored
        fork
            run_frame(cyc, nupd, nrun, nover, to);
            begin
                repeat (6) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check("start-in-run cycles", cyc, 32);
        check("start-in-run updates", nupd, 1);
        eng_auto = 1'b0;
        spr_done_man = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy || update || run_spr) bad++;
        end
        check("idle ignores spr_done/extra done", bad, 0);
        spr_done_man = 1'b0;
        eng_auto = 1'b1;

        // Reset mid-RUN
        run_len = 1024;
        write_entry(1, 1'b1, 2'd2, 9'd33, 9'd44);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!run_spr && guard < 10) begin
            @(posedge clk); #1; guard++;
        end
        check("midrun reached RUN", 32'(run_spr), 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun RUN_SPR after reset", 32'(run_spr), 0);
        check("midrun BUSY after reset", 32'(busy), 0);
        check("midrun TARGET_X after reset", 32'(target_x), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) bad++;
        end
        check("midrun no DONE", bad, 0);
        run_frame(cyc, nupd, nrun, nover, to);
        check("post-reset cycles", cyc, 10);
        check("post-reset en cleared", nupd, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sprite_sequencer.md
SPRITE_SEQUENCER -- requirements
Module: sprite_sequencer

Interface
REQ-001 SHALL have parameter N_SPR, default 4, the number of sprite table entries; N_SPR is a power of 2 and at most 16.
REQ-002 SHALL have these clock and reset ports: CLOCK_50 in 1 (the one clock); RESET_H in 1, synchronous active-high reset.
REQ-003 SHALL have these command ports: START in 1, a one-cycle frame-draw request; BUSY out 1, high from START acceptance until DONE.
REQ-004 SHALL have these table write ports: TBL_WE in 1; TBL_ADDR in log2(N_SPR); TBL_EN in 1; TBL_ID in 2; TBL_X in 9; TBL_Y in 9.
REQ-005 SHALL have these sprite engine ports: UPDATE out 1; RUN_SPR out 1; SPRITE_ID out 2; TARGET_X out 9; TARGET_Y out 9; SPR_DONE in 1.
REQ-006 SHALL have this status port: DONE out 1, a one-cycle pulse when all enabled entries have been drawn.

Function
REQ-007 SHALL hold an N_SPR-entry table of {en, id[1:0], x[8:0], y[8:0]}; a write with TBL_WE=1 updates entry TBL_ADDR at the clock edge.
REQ-008 SHALL accept table writes at any time, including while BUSY.
REQ-009 SHALL latch the active entry's id, x and y into output registers in LOAD; SPRITE_ID, TARGET_X and TARGET_Y SHALL stay constant from LOAD through the end of RUN, even if that entry is rewritten.
REQ-010 SHALL implement the FSM states IDLE, SCAN, LOAD, RUN, NEXT and FIN.
REQ-011 IDLE: on START=1, SHALL clear index idx to 0, set BUSY, and go to SCAN; START in any other state SHALL be ignored.
REQ-012 SCAN: if entry[idx].en=1, SHALL go to LOAD; otherwise SHALL go to NEXT; one cycle per entry examined.
REQ-013 LOAD: SHALL assert UPDATE for exactly one cycle with the targets already valid on the outputs, then go to RUN.
REQ-014 RUN: RUN_SPR SHALL equal (state==RUN && !SPR_DONE), decoded combinationally, so no engine cycle runs after done; on SPR_DONE=1, SHALL go to NEXT.
REQ-015 NEXT: if idx==N_SPR-1, SHALL go to FIN; otherwise SHALL increment idx and go to SCAN.
REQ-016 FIN: SHALL pulse DONE for one cycle, clear BUSY, and return to IDLE.
REQ-017 UPDATE and RUN_SPR SHALL never be high in the same cycle.
REQ-018 SPR_DONE outside RUN SHALL be ignored.
REQ-019 An all-disabled table SHALL produce DONE exactly 2*N_SPR+2 cycles after START, with no UPDATE and no RUN_SPR.
REQ-020 Each enabled entry SHALL cost 1 SCAN + 1 LOAD + RUN cycles + 1 NEXT; with the engine's 32x32 sweep, RUN lasts 1024 cycles of RUN_SPR plus 1 done cycle.
REQ-021 idx SHALL not wrap beyond N_SPR-1; entries SHALL be drawn in ascending index order, so higher indices draw on top.
REQ-022 Coordinates SHALL pass through unmodified at 9 bits; no clipping is done in this block.

Reset
REQ-023 RESET_H=1 at a clock edge SHALL force IDLE, idx=0, BUSY=0, DONE=0, UPDATE=0, and output targets and ID to 0; RUN_SPR=0 follows from IDLE.
REQ-024 Reset SHALL clear all table en bits to 0; id, x and y SHALL be left unreset.
REQ-025 Reset mid-RUN SHALL drop RUN_SPR in the cycle after the reset edge and SHALL not pulse DONE.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE..FIN), the sprite entry struct, and the constant SPR_DIM=32.
REQ-027 The table SHALL be a sub-module sprite_table with a synchronous write port, asynchronous read by idx, and reset-cleared enable bits; the FSM SHALL live in sprite_sequencer.

Verification
REQ-028 Reset, then START with the table empty -> DONE exactly 10 cycles later (N_SPR=4), UPDATE and RUN_SPR never high.
REQ-029 Entry 2 = {en=1, id=3, x=100, y=50}, others disabled, START -> one UPDATE pulse with SPRITE_ID=3, TARGET_X=100, TARGET_Y=50; RUN_SPR high until SPR_DONE; then DONE.
REQ-030 All 4 entries enabled, engine model returns SPR_DONE after 1024 RUN cycles -> UPDATE order idx 0,1,2,3; total START-to-DONE = 4*(1+1+1025+1)+2 cycles.
REQ-031 Rewrite active entry 0 x=200 during RUN -> TARGET_X stays at its old value until NEXT; the next frame uses 200.
REQ-032 START pulsed during RUN; SPR_DONE injected in IDLE -> both ignored, no state change, no extra DONE.
REQ-033 RESET_H asserted for 1 cycle mid-RUN -> RUN_SPR=0 and BUSY=0 the next cycle, en bits cleared, no DONE; a following START gives DONE after 10 cycles.
